id_ex_pipe: RTL and testbench
=============================

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter OP_W, default 3, opcode field width in bits.
REQ-002 Parameter DATA_W, default 8, width of each source-operand field in bits.
REQ-003 Parameter RA_W, default 3, destination register address width in bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream (ID) beat present.
REQ-007 in_ready  output  1  stage can accept a beat this cycle.
REQ-008 in_opcode / in_rs1_data / in_rs2_data / in_rd  input  OP_W / DATA_W / DATA_W / RA_W  upstream payload.
REQ-009 flush  input  1  discard every beat held in the stage (branch/exception kill).
REQ-010 out_valid  output  1  downstream (EX) beat present.
REQ-011 out_ready  input  1  downstream accepts the beat this cycle.
REQ-012 out_opcode / out_rs1_data / out_rs2_data / out_rd  output  OP_W / DATA_W / DATA_W / RA_W  registered payload.

Function
REQ-013 The stage SHALL accept a beat when in_valid && in_ready, and SHALL deliver one when out_valid && out_ready.
REQ-014 A beat accepted into an empty stage SHALL appear on out_* with out_valid=1 on the next rising edge (latency 1 cycle).
REQ-015 While out_valid=1 && out_ready=0, out_* and out_valid SHALL hold stable.
REQ-016 Beats SHALL leave in acceptance order, with none dropped or duplicated, except as removed by flush.
REQ-017 Accept and deliver in the same cycle SHALL sustain 1 beat/cycle with out_valid continuously 1.
REQ-018 Deliver without accept SHALL clear out_valid next cycle, unless a held skid beat moves to out_* (REQ-025).
REQ-019 With out_valid=0, out_* payload SHALL retain its last loaded value; only out_valid qualifies it.
REQ-020 flush=1 SHALL clear out_valid and all internal valid state on the next edge; payload registers are unchanged.
REQ-021 A beat accepted in a flush cycle SHALL be discarded; a beat delivered in a flush cycle counts as delivered.
REQ-022 in_ready SHALL NOT depend on flush.

Reset
REQ-023 While rst=1: in_ready=0. On the edge with rst=1: out_valid=0, internal valid state=0, all out_* payload=0.
REQ-024 rst SHALL take priority over flush and over any handshake in the same cycle; the first beat can be accepted in the first cycle after rst deasserts.

Configuration
REQ-025 Macro ID_EX_PIPE_SKID_EN defined: one-entry skid register added; in_ready = !skid_valid, driven directly by a register (no combinational path from out_ready).
- Accept while out_valid=1 && out_ready=0 stores the beat in skid.
- On delivery, a valid skid beat moves to out_* on the same edge.
- Capacity 2 beats.
REQ-026 Macro not defined: no skid register; in_ready = !out_valid || out_ready (combinational); capacity 1 beat.
REQ-027 Both builds SHALL satisfy REQ-013..REQ-024 identically at the port level, except for in_ready timing and capacity.

Verification
REQ-028 Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_* all 0; first cycle after rst deasserts -> in_ready=1.
REQ-029 Single beat: in opcode=3'b101, rs1=8'hA5, rs2=8'h3C, rd=3'd6, out_ready=1 -> next cycle out_valid=1 with those exact values; following cycle out_valid=0.
REQ-030 Streaming: 8 back-to-back beats with rs1=8'h00..8'h07 and out_ready=1 -> out_valid=1 for 8 consecutive cycles, rs1 in order 00..07.
REQ-031 Backpressure: stream 00..07 while out_ready toggles 1,0,0,1,... -> every value delivered exactly once in order; payload stable during stalls.
- SKID_EN build: in_ready falls only after 2 beats are held.
- Non-skid build: in_ready falls in the first stall cycle.
REQ-032 Flush: hold 2 beats (SKID_EN) or 1 beat, assert flush for 1 cycle while presenting rs1=8'hEE -> out_valid=0 next cycle, 8'hEE never appears on out_*; next beat 8'h11 is delivered normally.
REQ-033 Priority: rst=1 and flush=1 in the same cycle, out_valid=1 beforehand -> reset values per REQ-023 (payload 0), not flush behaviour (payload unchanged).

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with valid/ready handshake and flush.
// Define ID_EX_PIPE_SKID_EN to add a one-entry skid buffer (registered in_ready, capacity 2).
module id_ex_pipe #(
    parameter int OP_W   = 3,
    parameter int DATA_W = 8,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_opcode,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic [RA_W-1:0]   out_rd
);

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [RA_W-1:0]   rd;
    } payload_t;

    payload_t in_beat;
    payload_t out_q, out_d;
    logic     out_valid_q, out_valid_d;
    logic     accept, deliver;

    assign in_beat = '{opcode: in_opcode, rs1: in_rs1_data, rs2: in_rs2_data, rd: in_rd};
    assign deliver = out_valid_q && out_ready;
    assign accept  = in_valid && in_ready;

`ifdef ID_EX_PIPE_SKID_EN
    payload_t skid_q, skid_d;
    logic     skid_valid_q, skid_valid_d;

    // in_ready comes straight off skid_valid_q; rst only gates it while in reset.
    assign in_ready = !rst && !skid_valid_q;

    always_comb begin
        // NOTE: every _d takes its _q value first so no path leaves it unassigned (no latch).
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || deliver) begin
            // Output slot frees up: the older skid beat wins over the incoming one.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = !rst && (!out_valid_q || out_ready);

    always_comb begin
        // NOTE: every _d takes its _q value first so no path leaves it unassigned (no latch).
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = in_beat;
            out_valid_d = 1'b1;
        end else if (deliver) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_opcode   = out_q.opcode;
    assign out_rs1_data = out_q.rs1;
    assign out_rs2_data = out_q.rs2;
    assign out_rd       = out_q.rd;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe; covers reset, streaming, backpressure, flush, priority.
module tb_id_ex_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [7:0] in_rs1_data;
    logic [7:0] in_rs2_data;
    logic [2:0] in_rd;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_opcode;
    logic [7:0] out_rs1_data;
    logic [7:0] out_rs2_data;
    logic [2:0] out_rd;

    int checks = 0;
    int errors = 0;

`ifdef ID_EX_PIPE_SKID_EN
    localparam int EXP_FIRST_LOW = 2;
`else
    localparam int EXP_FIRST_LOW = 1;
`endif

    id_ex_pipe #(.OP_W(3), .DATA_W(8), .RA_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_rd        (in_rd),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rd       (out_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] rd);
        in_valid    = v;
        in_opcode   = op;
        in_rs1_data = a;
        in_rs2_data = b;
        in_rd       = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int next_val;
        int exp_val;
        int first_low;
        logic stalled;
        logic [7:0] held;
        logic acc;
        logic [1:0] pat;

        // Reset with a beat presented
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 3'd7, 8'hFF, 8'hFF, 3'd7);
        tick();
        check("rst_in_ready_c1", in_ready, 0);
        check("rst_out_valid_c1", out_valid, 0);
        tick();
        check("rst_in_ready_c2", in_ready, 0);
        check("rst_out_valid_c2", out_valid, 0);
        check("rst_payload", {out_opcode, out_rs1_data, out_rs2_data, out_rd}, 0);
        rst = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Single beat
        drive(1'b1, 3'b101, 8'hA5, 8'h3C, 3'd6);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
        check("single_valid", out_valid, 1);
        check("single_opcode", out_opcode, 3'b101);
        check("single_rs1", out_rs1_data, 8'hA5);
        check("single_rs2", out_rs2_data, 8'h3C);
        check("single_rd", out_rd, 3'd6);
        tick();
        check("single_drain_valid", out_valid, 0);
        check("single_payload_retained", out_rs1_data, 8'hA5);

        // Streaming 8 back-to-back beats
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'd1, 8'(i), 8'h00, 3'd2);
            tick();
            check($sformatf("stream_valid_%0d", i), out_valid, 1);
            check($sformatf("stream_rs1_%0d", i), out_rs1_data, 32'(i));
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
        tick();
        check("stream_drain_valid", out_valid, 0);

        // Backpressure with out_ready pattern 1,0,0,1
        next_val = 0; exp_val = 0; first_low = -1; stalled = 1'b0; held = 8'h00;
        for (int c = 0; c < 60 && exp_val < 8; c++) begin
            pat = 2'(c % 4);
            out_ready = (pat == 2'd0 || pat == 2'd3);
            drive(next_val < 8, 3'd3, 8'(next_val), 8'h55, 3'd1);
            #1;
            if (stalled) begin
                check($sformatf("bp_hold_valid_c%0d", c), out_valid, 1);
                check($sformatf("bp_hold_rs1_c%0d", c), out_rs1_data, held);
            end
            if (!in_ready && first_low < 0) first_low = c;
            if (out_valid && out_ready) begin
                check($sformatf("bp_order_%0d", exp_val), out_rs1_data, 8'(exp_val));
                exp_val++;
            end
            stalled = out_valid && !out_ready;
            held    = out_rs1_data;
            acc     = in_valid && in_ready;
            tick();
            if (acc) next_val++;
        end
        check("bp_all_delivered", exp_val, 8);
        check("bp_first_in_ready_low", first_low, EXP_FIRST_LOW);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("bp_no_extra_beat", out_valid, 0);

        // Flush with the stage full
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 8'h20, 8'h00, 3'd3);
        tick();
`ifdef ID_EX_PIPE_SKID_EN
        drive(1'b1, 3'd2, 8'h21, 8'h00, 3'd3);
        tick();
`endif
        check("flush_pre_valid", out_valid, 1);
        drive(1'b1, 3'd2, 8'hEE, 8'h00, 3'd3);
        flush = 1'b1;
        #1;
        check("flush_in_ready_full", in_ready, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
        check("flush_valid", out_valid, 0);
        check("flush_payload_kept", out_rs1_data, 8'h20);
        tick();
        check("flush_no_skid_revival", out_valid, 0);
        out_ready = 1'b1;
        drive(1'b1, 3'd4, 8'h11, 8'h22, 3'd5);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
        check("flush_next_valid", out_valid, 1);
        check("flush_next_rs1", out_rs1_data, 8'h11);
        tick();
        check("flush_next_drain", out_valid, 0);

        // Beat accepted into an empty stage during flush is discarded
        drive(1'b1, 3'd6, 8'hEE, 8'h00, 3'd0);
        flush = 1'b1;
        #1;
        check("flush_in_ready_empty", in_ready, 1);
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
        check("flush_accept_discard_valid", out_valid, 0);
        check("flush_accept_discard_rs1", out_rs1_data, 8'h11);

        // rst has priority over flush
        out_ready = 1'b0;
        drive(1'b1, 3'd5, 8'h5A, 8'h6B, 3'd4);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00, 3'd0);
        check("prio_pre_valid", out_valid, 1);
        rst = 1'b1; flush = 1'b1;
        tick();
        check("prio_valid", out_valid, 0);
        check("prio_payload", {out_opcode, out_rs1_data, out_rs2_data, out_rd}, 0);
        check("prio_in_ready", in_ready, 0);
        rst = 1'b0; flush = 1'b0;
        #1;
        check("prio_post_in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
